lcd_timing_gen: RTL



---
 rtl/lcd_timing_pkg.sv | 46 ++++
 rtl/lcd_axis_cnt.sv | 64 ++++++
 rtl/lcd_timing_gen.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared types and constants for the LCD raster timing generator.
// The default panel is the 480x272 RGB-LCD set.
package lcd_timing_pkg;

    typedef enum logic [1:0] {
        PH_SYNC   = 2'd0,
        PH_BP     = 2'd1,
        PH_ACTIVE = 2'd2,
        PH_FP     = 2'd3
    } phase_e;

    localparam int unsigned DEF_H_ACTIVE = 480;
    localparam int unsigned DEF_H_FP     = 8;
    localparam int unsigned DEF_H_SYNC   = 4;
    localparam int unsigned DEF_H_BP     = 43;
    localparam int unsigned DEF_V_ACTIVE = 272;
    localparam int unsigned DEF_V_FP     = 4;
    localparam int unsigned DEF_V_SYNC   = 4;
    localparam int unsigned DEF_V_BP     = 12;
    localparam int unsigned DEF_CNT_W    = 11;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RGB_WHITE;
            3'd1:    c = RGB_YELLOW;
            3'd2:    c = RGB_CYAN;
            3'd3:    c = RGB_GREEN;
            3'd4:    c = RGB_MAGENTA;
            3'd5:    c = RGB_RED;
            3'd6:    c = RGB_BLUE;
            default: c = RGB_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_axis_cnt.sv
// One raster axis: position counter plus SYNC/BP/ACTIVE/FP phase FSM.
// Exposes next-cycle count/phase so the top can register decoded outputs in step.
module lcd_axis_cnt
    import lcd_timing_pkg::*;
#(
    parameter int unsigned SYNC   = 1,
    parameter int unsigned BP     = 1,
    parameter int unsigned ACTIVE = 1,
    parameter int unsigned FP     = 1,
    parameter int unsigned CNT_W  = 11
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             adv_i,
    output logic [CNT_W-1:0] cnt_nxt_o,
    output phase_e           ph_nxt_o,
    output logic             wrap_o
);

    localparam logic [CNT_W-1:0] END_SYNC = CNT_W'(SYNC - 1);
    localparam logic [CNT_W-1:0] END_BP   = CNT_W'(SYNC + BP - 1);
    localparam logic [CNT_W-1:0] END_ACT  = CNT_W'(SYNC + BP + ACTIVE - 1);
    localparam logic [CNT_W-1:0] END_FP   = CNT_W'(SYNC + BP + ACTIVE + FP - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    phase_e           ph_q, ph_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ph_q  <= PH_SYNC;
        end else begin
            cnt_q <= cnt_d;
            ph_q  <= ph_d;
        end
    end

    // Each phase is left on the advance that finishes its last position.
    always_comb begin
        ph_d  = ph_q;
        cnt_d = cnt_q;
        if (clr_i) begin
            ph_d  = PH_SYNC;
            cnt_d = '0;
        end else if (adv_i) begin
            cnt_d = (cnt_q == END_FP) ? '0 : cnt_q + 1'b1;
            case (ph_q)
                PH_SYNC:   if (cnt_q == END_SYNC) ph_d = PH_BP;
                PH_BP:     if (cnt_q == END_BP)   ph_d = PH_ACTIVE;
                PH_ACTIVE: if (cnt_q == END_ACT)  ph_d = PH_FP;
                PH_FP:     if (cnt_q == END_FP)   ph_d = PH_SYNC;
                default:                          ph_d = PH_SYNC;
            endcase
        end
    end

    always_comb begin
        wrap_o    = adv_i && !clr_i && (cnt_q == END_FP);
        cnt_nxt_o = cnt_d;
        ph_nxt_o  = ph_d;
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// RGB-LCD raster timing (HS/VS/DE/X/Y/FRAME_START) paced by a divided pixel wave on CLK.
// Optional colour-bar test pattern on PAT_RGB when LCD_TEST_PATTERN_EN is defined.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned CNT_W    = DEF_CNT_W
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic             PCLK_DIV,
    output logic             PIX_STB,
    output logic             HS,
    output logic             VS,
    output logic             DE,
    output logic [CNT_W-1:0] X,
    output logic [CNT_W-1:0] Y,
    output logic             FRAME_START,
    output logic [15:0]      PAT_RGB
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    if (H_TOTAL >= (1 << CNT_W)) begin : g_h_total_chk
        $error("lcd_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (V_TOTAL >= (1 << CNT_W)) begin : g_v_total_chk
        $error("lcd_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end

    logic             pclk_q;
    logic             tick;
    logic [CNT_W-1:0] h_nxt, v_nxt;
    phase_e           h_ph_nxt, v_ph_nxt;
    logic             h_wrap, v_wrap;

    // pclk_q resets high so a wave already high out of reset is not a rising edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pclk_q <= 1'b1;
        else     pclk_q <= PCLK_DIV;
    end

    assign tick = EN & PCLK_DIV & ~pclk_q;

    lcd_axis_cnt #(
        .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .FP(H_FP), .CNT_W(CNT_W)
    ) u_h_axis (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clr_i    (~EN),
        .adv_i    (tick),
        .cnt_nxt_o(h_nxt),
        .ph_nxt_o (h_ph_nxt),
        .wrap_o   (h_wrap)
    );

    lcd_axis_cnt #(
        .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .FP(V_FP), .CNT_W(CNT_W)
    ) u_v_axis (
        .clk_i    (CLK),
        .rst_i    (RST),
        .clr_i    (~EN),
        .adv_i    (h_wrap),
        .cnt_nxt_o(v_nxt),
        .ph_nxt_o (v_ph_nxt),
        .wrap_o   (v_wrap)
    );

    logic             stb_q, stb_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             de_q, de_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic             fs_q, fs_d;

    // Decode from post-update counters; outputs hold between ticks.
    always_comb begin
        stb_d = tick;
        fs_d  = 1'b0;
        hs_d  = hs_q;
        vs_d  = vs_q;
        de_d  = de_q;
        x_d   = x_q;
        y_d   = y_q;
        if (!EN) begin
            hs_d = 1'b1;
            vs_d = 1'b1;
            de_d = 1'b0;
            x_d  = '0;
            y_d  = '0;
        end else if (tick) begin
            hs_d = !(h_nxt < CNT_W'(H_SYNC));
            vs_d = !(v_nxt < CNT_W'(V_SYNC));
            de_d = (h_ph_nxt == PH_ACTIVE) && (v_ph_nxt == PH_ACTIVE);
            x_d  = de_d ? h_nxt - CNT_W'(H_SYNC + H_BP) : '0;
            y_d  = de_d ? v_nxt - CNT_W'(V_SYNC + V_BP) : '0;
            fs_d = h_wrap && v_wrap;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stb_q <= 1'b0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
            de_q  <= 1'b0;
            x_q   <= '0;
            y_q   <= '0;
            fs_q  <= 1'b0;
        end else begin
            stb_q <= stb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            de_q  <= de_d;
            x_q   <= x_d;
            y_q   <= y_d;
            fs_q  <= fs_d;
        end
    end

    assign PIX_STB     = stb_q;
    assign HS          = hs_q;
    assign VS          = vs_q;
    assign DE          = de_q;
    assign X           = x_q;
    assign Y           = y_q;
    assign FRAME_START = fs_q;

`ifdef LCD_TEST_PATTERN_EN
    logic [15:0] pat_q, pat_d;

    always_comb begin
        pat_d = pat_q;
        if (!EN)
            pat_d = '0;
        else if (tick)
            pat_d = de_d ? bar_colour(3'((32'(x_d) * 32'd8) / 32'(H_ACTIVE))) : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) pat_q <= '0;
        else     pat_q <= pat_d;
    end

    assign PAT_RGB = pat_q;
`else
    assign PAT_RGB = '0;
`endif

endmodule
